// File: rtl/mig_7series_v4_2_axi_mc_defs.sv
// Shared helpers for the axi_mc shallow-FIFO family: sizing and parameter legality.
package mig_7series_v4_2_axi_mc_defs;

    // Number of bits needed to hold values 0..v-1 (ceil(log2(v))), 0 for v<=1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Address width for a storage array of the given depth (at least one bit).
    function automatic int unsigned addr_width(input int unsigned depth);
        return (clog2(depth) < 1) ? 1 : clog2(depth);
    endfunction

    // True when the width, depth and threshold combination is legal.
    function automatic bit prot_fifo_params_legal(
        input int unsigned width,
        input int unsigned depth,
        input int unsigned afull_thresh,
        input int unsigned aempty_thresh
    );
        return (width >= 1) && (depth >= 1) && (depth <= 64) &&
               (afull_thresh >= 1) && (afull_thresh <= depth) &&
               (aempty_thresh < depth);
    endfunction

endpackage

// File: rtl/mig_7series_v4_2_axi_mc_srl_array.sv
// Shift-register storage with a combinational addressed read; no reset so it maps to SRLs.
module mig_7series_v4_2_axi_mc_srl_array
    import mig_7series_v4_2_axi_mc_defs::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AWIDTH = addr_width(DEPTH)
) (
    input  logic              clk,
    input  logic              shift_en_i,
    input  logic [WIDTH-1:0]  din_i,
    input  logic [AWIDTH-1:0] addr_i,
    output logic [WIDTH-1:0]  dout_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Shift every entry up one place and load the new word at the bottom.
    always_ff @(posedge clk) begin
        if (shift_en_i) begin
            mem_q[0] <= din_i;
            for (int i = 1; i < int'(DEPTH); i++) begin
                mem_q[i] <= mem_q[i-1];
            end
        end
    end

    // Addressed read; out-of-range addresses (non power-of-two depth) read zero.
    always_comb begin
        dout_o = '0;
        if (32'(addr_i) < DEPTH) begin
            dout_o = mem_q[addr_i];
        end
    end

endmodule

// File: rtl/mig_7series_v4_2_axi_mc_prot_fifo.sv
// Protected first-word-fall-through shallow FIFO: occupancy count, thresholds, sticky errors.
module mig_7series_v4_2_axi_mc_prot_fifo
    import mig_7series_v4_2_axi_mc_defs::*;
#(
    parameter int unsigned C_WIDTH         = 8,
    parameter int unsigned C_DEPTH         = 16,
    parameter int unsigned C_AFULL_THRESH  = 14,
    parameter int unsigned C_AEMPTY_THRESH = 1,
    localparam int unsigned C_CWIDTH       = clog2(C_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [C_WIDTH-1:0]  din,
    input  logic                rd_en,
    output logic [C_WIDTH-1:0]  dout,
    output logic                full,
    output logic                a_full,
    output logic                empty,
    output logic                a_empty,
    output logic [C_CWIDTH-1:0] count,
    input  logic                err_clr,
    output logic                overflow,
    output logic                underflow
);

    localparam int unsigned AWIDTH = addr_width(C_DEPTH);

    // Reject illegal configurations at elaboration.
    if (!prot_fifo_params_legal(C_WIDTH, C_DEPTH, C_AFULL_THRESH, C_AEMPTY_THRESH)) begin : g_param_err
        $error("mig_7series_v4_2_axi_mc_prot_fifo: illegal width/depth/threshold parameters");
    end

    logic [C_CWIDTH-1:0] count_q, count_d;
    logic                full_q, full_d;
    logic                a_full_q, a_full_d;
    logic                empty_q, empty_d;
    logic                a_empty_q, a_empty_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;
    logic                rd_acc_c, wr_acc_c;
    logic [AWIDTH-1:0]   rd_addr_c;
    logic [C_WIDTH-1:0]  srl_dout_c;

    // Accept decisions; a write while full is taken only alongside a read that frees a slot.
    assign rd_acc_c = rd_en & ~empty_q;
    assign wr_acc_c = wr_en & (~full_q | rd_en);

    // Oldest entry lives at count-1.
    assign rd_addr_c = AWIDTH'(count_q - C_CWIDTH'(1));

    mig_7series_v4_2_axi_mc_srl_array #(
        .WIDTH (C_WIDTH),
        .DEPTH (C_DEPTH)
    ) u_srl_array (
        .clk        (clk),
        .shift_en_i (wr_acc_c),
        .din_i      (din),
        .addr_i     (rd_addr_c),
        .dout_o     (srl_dout_c)
    );

    // Next count, registered flags derived from it, and sticky error updates.
    always_comb begin
        count_d = count_q;
        if (wr_acc_c && !rd_acc_c) begin
            count_d = count_q + C_CWIDTH'(1);
        end else if (rd_acc_c && !wr_acc_c) begin
            count_d = count_q - C_CWIDTH'(1);
        end
        full_d      = (count_d == C_CWIDTH'(C_DEPTH));
        a_full_d    = (count_d >= C_CWIDTH'(C_AFULL_THRESH));
        empty_d     = (count_d == '0);
        a_empty_d   = (count_d <= C_CWIDTH'(C_AEMPTY_THRESH));
        overflow_d  = (overflow_q & ~err_clr) | (wr_en & ~wr_acc_c);
        underflow_d = (underflow_q & ~err_clr) | (rd_en & empty_q);
    end

    // State registers; storage itself is left unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            full_q      <= 1'b0;
            a_full_q    <= 1'b0;
            empty_q     <= 1'b1;
            a_empty_q   <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            full_q      <= full_d;
            a_full_q    <= a_full_d;
            empty_q     <= empty_d;
            a_empty_q   <= a_empty_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Stale storage is hidden whenever the FIFO is empty.
    assign dout      = empty_q ? '0 : srl_dout_c;
    assign full      = full_q;
    assign a_full    = a_full_q;
    assign empty     = empty_q;
    assign a_empty   = a_empty_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_mig_7series_v4_2_axi_mc_prot_fifo.sv
// Directed bench for the protected shallow FIFO at default parameters (8 bits x 16).
module tb_mig_7series_v4_2_axi_mc_prot_fifo;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] din;
    logic       rd_en;
    logic [7:0] dout;
    logic       full;
    logic       a_full;
    logic       empty;
    logic       a_empty;
    logic [4:0] count;
    logic       err_clr;
    logic       overflow;
    logic       underflow;

    int total = 0;
    int bad   = 0;

    mig_7series_v4_2_axi_mc_prot_fifo dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .din       (din),
        .rd_en     (rd_en),
        .dout      (dout),
        .full      (full),
        .a_full    (a_full),
        .empty     (empty),
        .a_empty   (a_empty),
        .count     (count),
        .err_clr   (err_clr),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        err_clr = 1'b0;
        din     = 8'h00;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        repeat (3) tick();

        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_a_empty", 32'(a_empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_a_full", 32'(a_full), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Fill with 0x01..0x10
        for (int i = 1; i <= 16; i++) begin
            wr_en = 1'b1;
            din   = 8'(i);
            tick();
            chk("fill_count", 32'(count), 32'(i));
            chk("fill_a_full", 32'(a_full), (i >= 14) ? 32'd1 : 32'd0);
            chk("fill_full", 32'(full), (i == 16) ? 32'd1 : 32'd0);
            chk("fill_empty", 32'(empty), 32'd0);
            chk("fill_a_empty", 32'(a_empty), (i <= 1) ? 32'd1 : 32'd0);
            chk("fill_dout", 32'(dout), 32'h01);
        end

        // Write alone while full is refused
        wr_en = 1'b1;
        din   = 8'hEE;
        tick();
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd16);
        chk("ovf_dout", 32'(dout), 32'h01);
        chk("ovf_full", 32'(full), 32'd1);

        // Full with read+write: pass-through, 0xAA becomes newest
        wr_en = 1'b1;
        rd_en = 1'b1;
        din   = 8'hAA;
        tick();
        chk("rw_full_count", 32'(count), 32'd16);
        chk("rw_full_dout", 32'(dout), 32'h02);
        chk("rw_full_ovf_sticky", 32'(overflow), 32'd1);
        chk("rw_full_underflow", 32'(underflow), 32'd0);

        // Drain: 0x02..0x10 then 0xAA
        idle();
        for (int k = 0; k < 16; k++) begin
            chk("drain_dout", 32'(dout), (k < 15) ? 32'(k + 2) : 32'hAA);
            rd_en = 1'b1;
            tick();
            chk("drain_count", 32'(count), 32'(15 - k));
            chk("drain_a_empty", 32'(a_empty), ((15 - k) <= 1) ? 32'd1 : 32'd0);
            chk("drain_empty", 32'(empty), (k == 15) ? 32'd1 : 32'd0);
            chk("drain_full", 32'(full), 32'd0);
        end
        chk("drained_dout", 32'(dout), 32'd0);
        chk("drained_underflow", 32'(underflow), 32'd0);

        // Empty with read+write: read refused, write accepted
        rd_en = 1'b1;
        wr_en = 1'b1;
        din   = 8'h55;
        tick();
        chk("udf_flag", 32'(underflow), 32'd1);
        chk("udf_count", 32'(count), 32'd1);
        chk("udf_dout", 32'(dout), 32'h55);
        chk("udf_empty", 32'(empty), 32'd0);

        // err_clr alone clears both flags
        idle();
        err_clr = 1'b1;
        tick();
        chk("clr_overflow", 32'(overflow), 32'd0);
        chk("clr_underflow", 32'(underflow), 32'd0);
        chk("clr_count", 32'(count), 32'd1);

        // err_clr with no errors pending keeps them clear
        tick();
        chk("clr_idle_overflow", 32'(overflow), 32'd0);
        chk("clr_idle_underflow", 32'(underflow), 32'd0);

        // Refill to full with 0x21..0x2F
        idle();
        for (int i = 1; i <= 15; i++) begin
            wr_en = 1'b1;
            din   = 8'(8'h20 + i);
            tick();
        end
        chk("refill_count", 32'(count), 32'd16);
        chk("refill_full", 32'(full), 32'd1);
        chk("refill_dout", 32'(dout), 32'h55);

        // Overflowing write in the same cycle as err_clr: set wins
        wr_en   = 1'b1;
        din     = 8'hEE;
        err_clr = 1'b1;
        tick();
        chk("clr_vs_set_overflow", 32'(overflow), 32'd1);
        chk("clr_vs_set_count", 32'(count), 32'd16);

        idle();
        err_clr = 1'b1;
        tick();
        chk("clr_after_overflow", 32'(overflow), 32'd0);

        // Read down to 7 entries
        idle();
        for (int k = 0; k < 9; k++) begin
            rd_en = 1'b1;
            tick();
        end
        chk("part_count", 32'(count), 32'd7);
        chk("part_dout", 32'(dout), 32'h29);
        chk("part_a_full", 32'(a_full), 32'd0);

        // Asynchronous reset mid-burst, checked before the next clock edge
        idle();
        wr_en = 1'b1;
        din   = 8'h99;
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_dout", 32'(dout), 32'd0);
        chk("arst_a_empty", 32'(a_empty), 32'd1);
        chk("arst_full", 32'(full), 32'd0);

        idle();
        tick();
        chk("arst_hold_count", 32'(count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Normal operation after release
        wr_en = 1'b1;
        din   = 8'h77;
        tick();
        din   = 8'h88;
        tick();
        chk("post_count", 32'(count), 32'd2);
        chk("post_dout", 32'(dout), 32'h77);
        idle();
        rd_en = 1'b1;
        tick();
        chk("post_rd_count", 32'(count), 32'd1);
        chk("post_rd_dout", 32'(dout), 32'h88);
        tick();
        chk("post_rd2_empty", 32'(empty), 32'd1);
        chk("post_rd2_dout", 32'(dout), 32'd0);
        chk("post_underflow", 32'(underflow), 32'd0);

        idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
